tap_buffer: RTL

TAP_BUFFER -- requirements
Module: tap_buffer

---
 rtl/conv_buf_pkg.sv | 19 +
 rtl/tap_buffer_tap_ram.sv | 35 +++
 rtl/tap_buffer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/conv_buf_pkg.sv
// Shared constants and tap addressing helper for the circular tap buffer.
package conv_buf_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_NUM_TAPS   = 3;

  // Working width for pointer arithmetic; callers keep the low ADDR_WIDTH
  // bits, which yields the result modulo DEPTH (DEPTH is a power of two).
  localparam int unsigned IDX_W = 16;

  // Storage index of the sample 'off' positions behind the one just before ptr.
  function automatic logic [IDX_W-1:0] tap_index(input logic [IDX_W-1:0] ptr,
                                                 input logic [IDX_W-1:0] off);
    return ptr - IDX_W'(1) - off;
  endfunction

endpackage

// File: rtl/tap_buffer_tap_ram.sv
// Sample storage for tap_buffer: one write port, NUM_TAPS asynchronous
// read ports, contents cleared by aclr.
module tap_ram
  import conv_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_TAPS   = DEF_NUM_TAPS
) (
  input  logic                           clk,
  input  logic                           aclr,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write port; whole array cleared on reset.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_rd
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/tap_buffer.sv
// Circular sample buffer with NUM_TAPS registered read taps addressed by
// distance back from the newest sample.
// Optional build macro TAP_BUFFER_BYPASS_EN: taps see the post-write state
// (same-cycle write forwarded at offset 0, validity from updated occupancy).
module tap_buffer
  import conv_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_TAPS   = DEF_NUM_TAPS
) (
  input  logic                           clk,
  input  logic                           aclr,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           pop,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0] tap_offset,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] tap_data,
  output logic [NUM_TAPS-1:0]            tap_valid,
  output logic [ADDR_WIDTH:0]            count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]               count_q, count_next;
  logic                           wr_en, rd_en;
  logic [ADDR_WIDTH-1:0]          base_ptr;
  logic [CNT_W-1:0]               base_cnt;
  logic [NUM_TAPS*ADDR_WIDTH-1:0] raddr;
  logic [NUM_TAPS*DATA_WIDTH-1:0] rdata;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full || pop;
  assign count    = count_q;

  assign wr_en = in_valid && in_ready && !flush;
  assign rd_en = pop && !empty && !flush;

  // Occupancy after this edge's accepted write/pop.
  always_comb begin
    count_next = count_q;
    if (wr_en && !rd_en)      count_next = count_q + CNT_W'(1);
    else if (!wr_en && rd_en) count_next = count_q - CNT_W'(1);
  end

  // Pointer and occupancy state; flush resets them but leaves storage alone.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count_q <= count_next;
    end
  end

`ifdef TAP_BUFFER_BYPASS_EN
  logic [ADDR_WIDTH-1:0] wr_ptr_next;
  assign wr_ptr_next = wr_en ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
  assign base_ptr    = wr_ptr_next;
  assign base_cnt    = count_next;
`else
  assign base_ptr = wr_ptr;
  assign base_cnt = count_q;
`endif

  tap_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_TAPS   (NUM_TAPS)
  ) u_ram (
    .clk   (clk),
    .aclr  (aclr),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    logic [ADDR_WIDTH-1:0] off;
    logic                  hit;
    logic [DATA_WIDTH-1:0] sample;

    assign off = tap_offset[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign raddr[i*ADDR_WIDTH +: ADDR_WIDTH] =
      ADDR_WIDTH'(tap_index(IDX_W'(base_ptr), IDX_W'(off)));
    assign hit = ({1'b0, off} < base_cnt);

`ifdef TAP_BUFFER_BYPASS_EN
    // Offset 0 addresses the slot being written this cycle, so forward it.
    assign sample = (wr_en && off == '0) ? in_data : rdata[i*DATA_WIDTH +: DATA_WIDTH];
`else
    assign sample = rdata[i*DATA_WIDTH +: DATA_WIDTH];
`endif

    // Registered tap output; data only updates when the tap is in range.
    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        tap_data[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
        tap_valid[i]                         <= 1'b0;
      end else if (flush) begin
        tap_valid[i] <= 1'b0;
      end else begin
        tap_valid[i] <= hit;
        if (hit) tap_data[i*DATA_WIDTH +: DATA_WIDTH] <= sample;
      end
    end
  end

endmodule
